// File: rtl/riscv_alu_pkg.sv
// Shared op codes, FSM state type and op-classification helpers for the sequential RISC-V ALU.
package riscv_alu_pkg;

    localparam logic [4:0] OP_AND    = 5'd0;
    localparam logic [4:0] OP_OR     = 5'd1;
    localparam logic [4:0] OP_ADD    = 5'd2;
    localparam logic [4:0] OP_XOR    = 5'd3;
    localparam logic [4:0] OP_SLL    = 5'd4;
    localparam logic [4:0] OP_SRL    = 5'd5;
    localparam logic [4:0] OP_SUB    = 5'd6;
    localparam logic [4:0] OP_SLT    = 5'd7;
    localparam logic [4:0] OP_SLTU   = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_NOR    = 5'd12;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    // True when operand A is interpreted as two's complement.
    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider sharing one 2*XLEN working register.
module riscv_muldiv_iter
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc, acc_nxt, prod;
    logic [XLEN-1:0]   opnd, quo, rem;
    logic [XLEN:0]     sum, trial;
    logic [CW-1:0]     cnt;
    logic [4:0]        op_q;
    logic              is_div, neg_res, neg_rem;
    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;

    assign sa    = is_signed_op(op) && a[XLEN-1];
    assign sb    = is_signed_op(op) && (op != OP_MULHSU) && b[XLEN-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (is_div)
            acc_nxt = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nxt = {sum, acc[XLEN-1:1]};
    end

    // Sign fix-up on the value the final iteration produces, so the result lands on that same edge.
    always_comb begin
        prod = neg_res ? -acc_nxt : acc_nxt;
        quo  = neg_res ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result = quo;
            OP_REM, OP_REMU:               result = rem;
            default:                       result = '0;
        endcase
    end

    assign last = step && (cnt == CW'(XLEN-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            op_q    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (start) begin
            is_div  <= (op >= OP_DIV);
            acc     <= (op >= OP_DIV) ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opnd    <= (op >= OP_DIV) ? mag_b : mag_a;
            cnt     <= '0;
            op_q    <= op;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_seq_alu.sv
// Sequential RISC-V ALU: single-cycle simple ops, XLEN-cycle mul/div, valid/ready handshake on both sides.
module riscv_seq_alu
    import riscv_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_Out,
    output logic            zero
);
    state_t          state, state_nxt;
    logic            accept, div0, ovf, special, fast;
    logic            md_last;
    logic [XLEN-1:0] simple_res, md_result;

    assign accept  = in_valid && in_ready;
    assign div0    = (B == '0);
    assign ovf     = (A == {1'b1, {(XLEN-1){1'b0}}}) && (&B);
    // Divide-by-zero and signed overflow are resolved here instead of iterating.
    assign special = ((op >= OP_DIV) && (op <= OP_REMU) && div0) ||
                     (((op == OP_DIV) || (op == OP_REM)) && ovf);
    assign fast    = !is_muldiv(op) || special;

    always_comb begin
        case (op)
            OP_AND:          simple_res = A & B;
            OP_OR:           simple_res = A | B;
            OP_ADD:          simple_res = A + B;
            OP_XOR:          simple_res = A ^ B;
            OP_SLL:          simple_res = A << B[SHW-1:0];
            OP_SRL:          simple_res = A >> B[SHW-1:0];
            OP_SUB:          simple_res = A - B;
            OP_SLT:          simple_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLTU:         simple_res = {{(XLEN-1){1'b0}}, A < B};
            OP_SRA:          simple_res = $signed(A) >>> B[SHW-1:0];
            OP_NOR:          simple_res = ~(A | B);
            OP_DIV, OP_DIVU: simple_res = div0 ? '1 : A;
            OP_REM, OP_REMU: simple_res = div0 ? A : '0;
            default:         simple_res = '0;
        endcase
    end

    riscv_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && !fast),
        .step   (state == BUSY),
        .op     (op),
        .a      (A),
        .b      (B),
        .last   (md_last),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast ? DONE : BUSY;
            BUSY:    if (md_last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst)                 ALU_Out <= '0;
        else if (accept && fast) ALU_Out <= simple_res;
        else if (md_last)        ALU_Out <= md_result;
    end

    assign zero = (ALU_Out == '0);

endmodule

// File: doc/riscv_seq_alu.md
RISCV_SEQ_ALU -- requirements
Module: riscv_seq_alu

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 32 and 64.
REQ-002 Parameter SHW, default $clog2(XLEN): number of shift-amount bits taken from B.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: an operation is offered on op/A/B.
REQ-006 Port in_ready, output, 1: the block accepts an operation this cycle.
REQ-007 Port op, input, 5: operation code, per REQ-012.
REQ-008 Ports A and B, input, XLEN each: operands.
REQ-009 Port out_valid, output, 1: ALU_Out and zero hold a valid result.
REQ-010 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-011 Ports ALU_Out (output, XLEN): result; zero (output, 1): high iff ALU_Out == 0.

Function
REQ-012 Op codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT (signed), 8 SLTU, 9 SRA, 12 NOR, 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code is a simple op with result 0.
REQ-013 Shifts use B[SHW-1:0] only; ADD/SUB wrap modulo 2^XLEN; SLT/SLTU results are zero-extended 0 or 1.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 in_ready = 1 only in IDLE; a transfer is accepted when in_valid and in_ready are both high at a clock edge.
REQ-016 Simple op (codes 0-15 and unlisted codes): IDLE -> DONE on acceptance; out_valid is high from the next cycle (latency 1).
REQ-017 Multiply or divide op: IDLE -> BUSY on acceptance; exactly XLEN iterations at one per cycle, then -> DONE; out_valid is high XLEN+1 cycles after acceptance.
REQ-018 Multiply: radix-2 shift-add on magnitudes with sign fix-up. MUL returns the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU return the high XLEN bits (signed×signed, signed×unsigned, unsigned×unsigned).
REQ-019 Divide: radix-2 restoring division on magnitudes. Quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-020 Divide by zero: DIV/DIVU return all-ones and REM/REMU return A. This goes IDLE -> DONE with latency 1, with no BUSY.
REQ-021 Signed overflow (A = -2^(XLEN-1), B = -1): DIV returns A and REM returns 0. Latency 1, with no BUSY.
REQ-022 DONE: ALU_Out, zero and out_valid stay stable until out_ready is high. DONE -> IDLE on the edge where out_ready = 1.
REQ-023 Operands and op are captured at acceptance; input changes during BUSY or DONE have no effect.
REQ-024 in_valid while not in IDLE is ignored and is not queued.

Reset
REQ-025 On a rising edge with rst = 1: state = IDLE, out_valid = 0, ALU_Out = 0, zero = 1, and all iteration counters and working registers are cleared.
REQ-026 rst takes priority in any state; an operation in BUSY or DONE is discarded with no output.
REQ-027 in_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-028 Package riscv_alu_pkg holds: the op-code constants of REQ-012, the FSM state type, and the helper functions is_muldiv and is_signed_op.
REQ-029 One sub-module, riscv_muldiv_iter, holds the shared shift-add / restoring-divide datapath and its iteration counter. The top level holds the FSM, the simple-op combinational logic and the result register.

Verification
REQ-030 XLEN=32, op=2, A=0xFFFFFFFF, B=1 -> ALU_Out=0, zero=1, out_valid high 1 cycle after acceptance.
REQ-031 op=9, A=0x80000000, B=0x00000024 (shift uses 4) -> ALU_Out=0xF8000000; op=7, A=0xFFFFFFFF, B=0 -> 1; op=8 with same operands -> 0.
REQ-032 op=17, A=0x80000000, B=0x80000000 -> ALU_Out=0x40000000, out_valid high exactly 33 cycles after acceptance, in_ready low throughout.
REQ-033 op=20, A=-7, B=2 -> 0xFFFFFFFD; op=22 with same operands -> 0xFFFFFFFF; op=21, B=0 -> 0xFFFFFFFF at latency 1; op=20, A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> ALU_Out stable and in_valid ignored; assert out_ready -> in_ready high the next cycle.
REQ-035 Assert rst mid-BUSY (cycle 10 of a DIVU) -> out_valid=0, ALU_Out=0, zero=1, in_ready=1 after rst drops; no stale result ever appears.
